// File: rtl/conv_frame_sequencer.sv
// ============================================================================
// Module   : conv_frame_sequencer
// Purpose  : Walks a KxK window across a frame in pixel RAM, feeds each window
//            to the convolution unit and writes its result with backpressure.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_frame_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int RESULT_WIDTH = 16,
  parameter int IMG_W        = 8,
  parameter int IMG_H        = 8,
  parameter int ADDR_WIDTH   = 6
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        frame_start,
  output logic                                        busy,
  output logic                                        frame_done,
  output logic                                        pix_rd_en,
  output logic [ADDR_WIDTH-1:0]                       pix_rd_addr,
  input  logic [DATA_WIDTH-1:0]                       pix_rd_data,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] win_data,
  output logic                                        conv_start,
  input  logic                                        conv_valid,
  input  logic [RESULT_WIDTH-1:0]                     conv_result,
  output logic                                        res_wr_en,
  output logic [ADDR_WIDTH-1:0]                       res_wr_addr,
  output logic [RESULT_WIDTH-1:0]                     res_wr_data,
  input  logic                                        res_wr_ready
);

  localparam int c_k2    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int c_tap_w = $clog2(c_k2 + 1);
  localparam int c_kx_w  = $clog2(KERNEL_SIZE + 1);
  localparam int c_ow    = IMG_W - KERNEL_SIZE + 1;
  localparam int c_oh    = IMG_H - KERNEL_SIZE + 1;

  localparam logic [ADDR_WIDTH-1:0] c_addr_one  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_col_last  = ADDR_WIDTH'(c_ow - 1);
  localparam logic [ADDR_WIDTH-1:0] c_row_last  = ADDR_WIDTH'(c_oh - 1);
  // Jump from the last tap of one kernel row to the first tap of the next.
  localparam logic [ADDR_WIDTH-1:0] c_tap_row_step = ADDR_WIDTH'(IMG_W - KERNEL_SIZE + 1);
  // Jump from the last window of an output row to the first of the next.
  localparam logic [ADDR_WIDTH-1:0] c_win_row_step = ADDR_WIDTH'(KERNEL_SIZE);
  localparam logic [c_tap_w-1:0]    c_tap_one      = c_tap_w'(1);
  localparam logic [c_tap_w-1:0]    c_tap_last_rd  = c_tap_w'(c_k2 - 1);
  localparam logic [c_tap_w-1:0]    c_tap_end      = c_tap_w'(c_k2);
  localparam logic [c_kx_w-1:0]     c_kx_one       = c_kx_w'(1);
  localparam logic [c_kx_w-1:0]     c_kx_last      = c_kx_w'(KERNEL_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_WRITE   = 3'd4,
    S_ADVANCE = 3'd5
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_row;
  logic [ADDR_WIDTH-1:0]   r_col;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [ADDR_WIDTH-1:0]   r_out_idx;
  logic [c_tap_w-1:0]      r_tap;
  logic [c_kx_w-1:0]       r_kx;
  logic                    r_busy;
  logic                    r_frame_done;
  logic                    r_pix_rd_en;
  logic [ADDR_WIDTH-1:0]   r_pix_rd_addr;
  logic                    r_conv_start;
  logic                    r_res_wr_en;
  logic [ADDR_WIDTH-1:0]   r_res_wr_addr;
  logic [RESULT_WIDTH-1:0] r_res_wr_data;
  logic [DATA_WIDTH-1:0]   r_win [c_k2];
  logic                    w_last_window;

  assign w_last_window = (r_col == c_col_last) && (r_row == c_row_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_row         <= '0;
      r_col         <= '0;
      r_base        <= '0;
      r_out_idx     <= '0;
      r_tap         <= '0;
      r_kx          <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_pix_rd_en   <= 1'b0;
      r_pix_rd_addr <= '0;
      r_conv_start  <= 1'b0;
      r_res_wr_en   <= 1'b0;
      r_res_wr_addr <= '0;
      r_res_wr_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_state       <= S_FETCH;
            r_busy        <= 1'b1;
            r_row         <= '0;
            r_col         <= '0;
            r_base        <= '0;
            r_out_idx     <= '0;
            r_tap         <= '0;
            r_kx          <= '0;
            r_pix_rd_en   <= 1'b1;
            r_pix_rd_addr <= '0;
          end
        end

        // Read for tap t is on the bus while r_tap == t; its data lands one
        // cycle later and is captured by the window register below.
        S_FETCH: begin
          if (r_tap == c_tap_end) begin
            r_tap        <= '0;
            r_conv_start <= 1'b1;
            r_state      <= S_ISSUE;
          end else begin
            r_tap <= r_tap + c_tap_one;
            if (r_tap == c_tap_last_rd) begin
              r_pix_rd_en   <= 1'b0;
              r_pix_rd_addr <= '0;
            end else if (r_kx == c_kx_last) begin
              r_kx          <= '0;
              r_pix_rd_addr <= r_pix_rd_addr + c_tap_row_step;
            end else begin
              r_kx          <= r_kx + c_kx_one;
              r_pix_rd_addr <= r_pix_rd_addr + c_addr_one;
            end
          end
        end

        S_ISSUE: begin
          r_conv_start <= 1'b0;
          r_state      <= S_WAIT;
        end

        S_WAIT: begin
          if (conv_valid) begin
            r_res_wr_data <= conv_result;
            r_res_wr_addr <= r_out_idx;
            r_res_wr_en   <= 1'b1;
            r_state       <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (res_wr_ready) begin
            r_res_wr_en  <= 1'b0;
            r_frame_done <= w_last_window;
            r_state      <= S_ADVANCE;
          end
        end

        S_ADVANCE: begin
          r_frame_done <= 1'b0;
          r_out_idx    <= r_out_idx + c_addr_one;
          if (w_last_window) begin
            r_busy  <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_state     <= S_FETCH;
            r_kx        <= '0;
            r_pix_rd_en <= 1'b1;
            if (r_col != c_col_last) begin
              r_col         <= r_col + c_addr_one;
              r_base        <= r_base + c_addr_one;
              r_pix_rd_addr <= r_base + c_addr_one;
            end else begin
              r_col         <= '0;
              r_row         <= r_row + c_addr_one;
              r_base        <= r_base + c_win_row_step;
              r_pix_rd_addr <= r_base + c_win_row_step;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Only FETCH writes the window, so it stays frozen through ISSUE and WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < c_k2; t++) r_win[t] <= '0;
    end else if (r_state == S_FETCH) begin
      for (int t = 0; t < c_k2; t++) begin
        if (r_tap == c_tap_w'(t + 1)) r_win[t] <= pix_rd_data;
      end
    end
  end

  for (genvar t = 0; t < c_k2; t++) begin : g_win_pack
    assign win_data[t*DATA_WIDTH +: DATA_WIDTH] = r_win[t];
  end

  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign pix_rd_en   = r_pix_rd_en;
  assign pix_rd_addr = r_pix_rd_addr;
  assign conv_start  = r_conv_start;
  assign res_wr_en   = r_res_wr_en;
  assign res_wr_addr = r_res_wr_addr;
  assign res_wr_data = r_res_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_conv_frame_sequencer.sv
// ============================================================================
// Module   : tb_conv_frame_sequencer
// Purpose  : Directed self-checking bench for conv_frame_sequencer (4x4 and 8x8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_conv_frame_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] win_sum(input logic [71:0] w);
    logic [15:0] s;
    s = '0;
    for (int t = 0; t < 9; t++) s = s + 16'(w[t*8 +: 8]);
    return s;
  endfunction

  // ---------------- 4x4 instance, pixel RAM[a] = a ----------------
  logic        fs4, busy4, fd4, rd_en4, cs4, cv4, we4, rdy4, spur4;
  logic [3:0]  rd_addr4, wa4;
  logic [7:0]  rd_data4;
  logic [71:0] win4;
  logic [15:0] cr4, wd4;
  int          cnt4;

  conv_frame_sequencer #(
    .DATA_WIDTH(8), .KERNEL_SIZE(3), .RESULT_WIDTH(16),
    .IMG_W(4), .IMG_H(4), .ADDR_WIDTH(4)
  ) dut4 (
    .clk(clk), .rst(rst), .frame_start(fs4), .busy(busy4), .frame_done(fd4),
    .pix_rd_en(rd_en4), .pix_rd_addr(rd_addr4), .pix_rd_data(rd_data4),
    .win_data(win4), .conv_start(cs4), .conv_valid(cv4), .conv_result(cr4),
    .res_wr_en(we4), .res_wr_addr(wa4), .res_wr_data(wd4), .res_wr_ready(rdy4)
  );

  always @(posedge clk) rd_data4 <= rd_en4 ? 8'(rd_addr4) : 8'hEE;

  always @(posedge clk or posedge rst) begin
    if (rst) cnt4 <= 0;
    else if (cs4) cnt4 <= 4;
    else if (cnt4 != 0) cnt4 <= cnt4 - 1;
  end
  assign cv4 = (cnt4 == 1) | spur4;
  assign cr4 = win_sum(win4);

  // ---------------- 8x8 instance, pixel RAM[a] = 1 ----------------
  logic        fs8, busy8, fd8, rd_en8, cs8, cv8, we8;
  logic        rdy8 = 1'b1;
  logic [5:0]  rd_addr8, wa8;
  logic [7:0]  rd_data8;
  logic [71:0] win8;
  logic [15:0] cr8, wd8;
  int          cnt8;

  conv_frame_sequencer dut8 (
    .clk(clk), .rst(rst), .frame_start(fs8), .busy(busy8), .frame_done(fd8),
    .pix_rd_en(rd_en8), .pix_rd_addr(rd_addr8), .pix_rd_data(rd_data8),
    .win_data(win8), .conv_start(cs8), .conv_valid(cv8), .conv_result(cr8),
    .res_wr_en(we8), .res_wr_addr(wa8), .res_wr_data(wd8), .res_wr_ready(rdy8)
  );

  always @(posedge clk) rd_data8 <= rd_en8 ? 8'd1 : 8'hEE;

  always @(posedge clk or posedge rst) begin
    if (rst) cnt8 <= 0;
    else if (cs8) cnt8 <= 4;
    else if (cnt8 != 0) cnt8 <= cnt8 - 1;
  end
  assign cv8 = (cnt8 == 1);
  assign cr8 = win_sum(win8);

  // ---------------- monitors (sample on falling edge) ----------------
  logic [3:0]  rd_aq[$];
  int          rd_cq[$];
  int          cs_q[$];
  logic [71:0] win_first;
  logic [3:0]  wa_q[$];
  logic [15:0] wd_q[$];
  int          fd_cnt4 = 0;
  logic [5:0]  wa8_q[$];
  logic [15:0] wd8_q[$];
  int          fd_cnt8 = 0;

  always @(negedge clk) begin
    if (rd_en4) begin
      rd_aq.push_back(rd_addr4);
      rd_cq.push_back(cyc);
    end
    if (cs4) begin
      if (cs_q.size() == 0) win_first = win4;
      cs_q.push_back(cyc);
    end
    if (we4 && rdy4) begin
      wa_q.push_back(wa4);
      wd_q.push_back(wd4);
    end
    if (fd4) fd_cnt4++;
    if (we8 && rdy8) begin
      wa8_q.push_back(wa8);
      wd8_q.push_back(wd8);
    end
    if (fd8) fd_cnt8++;
  end

  task automatic clear4();
    rd_aq.delete(); rd_cq.delete(); cs_q.delete();
    wa_q.delete(); wd_q.delete();
    fd_cnt4 = 0;
  endtask

  task automatic start4();
    @(posedge clk); #1 fs4 = 1'b1;
    @(posedge clk); #1 fs4 = 1'b0;
  endtask

  task automatic wait_idle4(input int budget);
    int n;
    n = 0;
    while (busy4 === 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("frame4_timeout_busy", 32'(busy4), 0);
  endtask

  task automatic check_frame4(input string tag);
    int exp_d[4];
    exp_d = '{45, 54, 81, 90};
    check({tag, "_nwr"}, wa_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wa_q.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 32'(wa_q[i]), i);
        check($sformatf("%s_data%0d", tag, i), 32'(wd_q[i]), exp_d[i]);
      end
    end
    check({tag, "_ndone"}, fd_cnt4, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

  initial begin
    int exp_rd[9];
    int n;
    exp_rd = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    fs4 = 1'b0; spur4 = 1'b0; rdy4 = 1'b1; fs8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_busy", 32'(busy4), 0);
    check("rst_done", 32'(fd4), 0);
    check("rst_rd_en", 32'(rd_en4), 0);
    check("rst_conv_start", 32'(cs4), 0);
    check("rst_wr_en", 32'(we4), 0);
    check("rst_win_nonzero", 32'(win4 != '0), 0);

    // Basic frame, first-window read sequence and window contents
    clear4();
    start4();
    check("start_busy", 32'(busy4), 1);
    check("start_rd_en", 32'(rd_en4), 1);
    check("start_rd_addr", 32'(rd_addr4), 0);
    wait_idle4(200);
    check_frame4("basic");
    check("basic_nrd", rd_aq.size(), 36);
    if (rd_aq.size() >= 9) begin
      for (int i = 0; i < 9; i++) begin
        check($sformatf("rd_addr%0d", i), 32'(rd_aq[i]), exp_rd[i]);
        check($sformatf("rd_cyc%0d", i), rd_cq[i] - rd_cq[0], i);
      end
      check("conv_start_nsamples", cs_q.size(), 4);
      if (cs_q.size() >= 1) check("conv_start_latency", cs_q[0] - rd_cq[8], 2);
    end
    check("win_tap0", 32'(win_first[7:0]), 0);
    check("win_tap8", 32'(win_first[71:64]), 10);

    // Backpressure on first write
    clear4();
    rdy4 = 1'b0;
    start4();
    n = 0;
    while (!we4 && n < 100) begin @(posedge clk); #1; n++; end
    check("bp_wr_en_seen", 32'(we4), 1);
    repeat (5) begin
      @(negedge clk);
      check("bp_wr_en", 32'(we4), 1);
      check("bp_addr", 32'(wa4), 0);
      check("bp_data", 32'(wd4), 45);
      check("bp_no_fetch", 32'(rd_en4), 0);
    end
    @(posedge clk); #1 rdy4 = 1'b1;
    wait_idle4(200);
    check_frame4("bp");

    // Spurious conv_valid / frame_start mid-frame, frame_start during frame_done
    clear4();
    start4();
    repeat (3) @(posedge clk);
    #1 spur4 = 1'b1; fs4 = 1'b1;
    @(posedge clk); #1 spur4 = 1'b0; fs4 = 1'b0;
    n = 0;
    while (!fd4 && n < 200) begin @(posedge clk); #1; n++; end
    check("spur_done_seen", 32'(fd4), 1);
    fs4 = 1'b1;
    @(posedge clk); #1 fs4 = 1'b0;
    check("fs_on_done_busy", 32'(busy4), 0);
    repeat (3) begin @(posedge clk); #1; end
    check("fs_on_done_busy_later", 32'(busy4), 0);
    check("fs_on_done_rd_en", 32'(rd_en4), 0);
    check_frame4("spur");

    // Asynchronous reset during WAIT of window 2
    clear4();
    start4();
    n = 0;
    while (cs_q.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
    check("rst_wait_reached", cs_q.size(), 2);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy4), 0);
    check("arst_rd_en", 32'(rd_en4), 0);
    check("arst_wr_en", 32'(we4), 0);
    check("arst_wr_addr", 32'(wa4), 0);
    check("arst_wr_data", 32'(wd4), 0);
    check("arst_win_nonzero", 32'(win4 != '0), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check("arst_nwr", wa_q.size(), 1);
    check("arst_ndone", fd_cnt4, 0);
    check("arst_idle", 32'(busy4), 0);
    clear4();
    start4();
    wait_idle4(200);
    check_frame4("after_rst");

    // Default 8x8 frame, all-ones pixels
    @(posedge clk); #1 fs8 = 1'b1;
    @(posedge clk); #1 fs8 = 1'b0;
    n = 0;
    while (busy8 === 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
    check("f8_timeout_busy", 32'(busy8), 0);
    check("f8_nwr", wa8_q.size(), 36);
    for (int i = 0; i < 36; i++) begin
      if (i < wa8_q.size()) begin
        check($sformatf("f8_addr%0d", i), 32'(wa8_q[i]), i);
        check($sformatf("f8_data%0d", i), 32'(wd8_q[i]), 9);
      end
    end
    check("f8_ndone", fd_cnt8, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
- Sequences the 3x3 convolution unit across a full image frame held in single-port pixel RAM.
- Fetches each KERNEL_SIZE x KERNEL_SIZE window in row-major scan order and presents it to the convolution unit.
- Pulses the unit's start, waits for its valid, then writes each result to a result RAM with backpressure.
- Sits between the pixel buffer / result buffer and the convolution datapath; kernel coefficients are supplied to the unit directly and are not handled here.

Parameters:
- DATA_WIDTH, 8, pixel width.
- KERNEL_SIZE, 3, window edge length; taps per window K2 = KERNEL_SIZE*KERNEL_SIZE.
- RESULT_WIDTH, 16, convolution result width.
- IMG_W, 8, frame width in pixels (>= KERNEL_SIZE).
- IMG_H, 8, frame height in pixels (>= KERNEL_SIZE).
- ADDR_WIDTH, 6, pixel and result RAM address width; must satisfy 2^ADDR_WIDTH >= IMG_W*IMG_H.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- frame_start  in  1  one-cycle request to process a frame; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted frame_start until frame_done.
- frame_done  out  1  one-cycle pulse after the final result write.
- pix_rd_en  out  1  pixel RAM read strobe.
- pix_rd_addr  out  ADDR_WIDTH  pixel RAM address.
- pix_rd_data  in  DATA_WIDTH  pixel RAM data, valid exactly 1 cycle after pix_rd_en.
- win_data  out  K2*DATA_WIDTH  registered window; tap t = ky*KERNEL_SIZE+kx at bits [t*DATA_WIDTH +: DATA_WIDTH].
- conv_start  out  1  one-cycle start pulse to the convolution unit.
- conv_valid  in  1  convolution unit result valid pulse.
- conv_result  in  RESULT_WIDTH  convolution unit result (signed).
- res_wr_en  out  1  result write request.
- res_wr_addr  out  ADDR_WIDTH  result address = out_row*(IMG_W-KERNEL_SIZE+1)+out_col.
- res_wr_data  out  RESULT_WIDTH  latched result.
- res_wr_ready  in  1  result sink accepts the write when res_wr_en && res_wr_ready.

Behaviour:
- Reset: state IDLE; all outputs 0; win_data 0; row/col/tap counters 0. Reset mid-frame aborts immediately; no write or frame_done follows.
- Output grid: OW = IMG_W-KERNEL_SIZE+1, OH = IMG_H-KERNEL_SIZE+1 (valid-only, no padding). Scan col-fastest, then row.
- IDLE: busy=0. frame_start=1 → FETCH with row=col=tap=0; busy=1 next cycle.
- FETCH: K2+1 cycles.
  - Cycles 0..K2-1: pix_rd_en=1, pix_rd_addr=(row+tap/K)*IMG_W+col+tap%K, tap increments.
  - Cycles 1..K2: capture pix_rd_data into win_data tap (t-1).
  - Then → ISSUE.
- ISSUE: conv_start=1 for exactly one cycle → WAIT. win_data is held constant from ISSUE until conv_valid.
- WAIT: on conv_valid, latch conv_result into res_wr_data → WRITE. No timeout.
- WRITE: res_wr_en=1 with stable addr/data until res_wr_ready=1 (accepted that cycle) → ADVANCE.
- ADVANCE:
  - col<OW-1: col++.
  - else col=0; if row<OH-1: row++ → FETCH.
  - Last window: frame_done=1 this cycle, busy=0 next cycle → IDLE.
- Minimum per window: K2+1 + 1 + conv latency (4) + 1 + 1 = 17 cycles at K=3.
- frame_start while busy: ignored, not queued.
- conv_valid outside WAIT: ignored.
- frame_start in the cycle frame_done is high: ignored (state not yet IDLE).
- No arithmetic on results; data is passed through unmodified at RESULT_WIDTH.

Test Plan:
- IMG_W=IMG_H=4, pixel RAM[a]=a, conv stub returns window sum 4 cycles after conv_start, res_wr_ready=1 → writes (addr,data) = (0,45),(1,54),(2,81),(3,90); frame_done pulses once; busy then low.
- Same setup, check first window → pix_rd_addr sequence 0,1,2,4,5,6,8,9,10 on consecutive cycles; win_data tap0=0, tap8=10; conv_start one cycle wide, issued one cycle after final capture.
- res_wr_ready held low 5 cycles during first write → res_wr_en stays high with addr 0 / data 45 stable; no FETCH reads issued until acceptance.
- frame_start re-pulsed mid-frame, and spurious conv_valid during FETCH → no effect; exactly 4 writes and 1 frame_done.
- rst asserted during WAIT of window 2 → all outputs 0 asynchronously; after release a new frame_start completes a full correct frame (45,54,81,90).
- Default 8x8 frame with pixel RAM[a]=1 → 36 writes, each data 9, addresses 0..35 in order.
